ghr_spec: RTL and testbench

Parametrised global history register with speculative fetch-time update and mispredict repair. It sits beside the branch predictor. Fetch shifts each predicted conditional-branch direction into a speculative history, and a small FIFO buffers those predicted bits until the branch resolves in EX. At resolution the block updates the committed history, compares actual against predicted, and on a mismatch rebuilds the speculative history from the committed copy. `hist_o` replaces the old 2-bit `local_src_o` as the predictor's history index.

---
 rtl/ghr_spec_pkg.sv | 14 +
 rtl/ghr_dir_fifo.sv | 64 ++++++
 rtl/ghr_spec.sv | 111 +++++++++++
 tb/tb_ghr_spec.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ghr_spec_pkg.sv
// Shared defaults and reset pattern for the global history register.
// Consumers: ghr_spec (macro GHR_SPEC_EN selects speculative mode).
package ghr_spec_pkg;

    localparam int unsigned HistLenDefault   = 8;
    localparam int unsigned CkptDepthDefault = 4;
    localparam int unsigned MaxHistLen       = 64;

    // Weakly-taken-recent: only the newest history bit set.
    function automatic logic [MaxHistLen-1:0] hist_reset_val();
        return {{(MaxHistLen-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ghr_dir_fifo.sv
// 1-bit-wide FIFO buffering predicted branch directions until resolution.
// Push while full is honoured only together with a pop; clear empties it.
module ghr_dir_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    input  logic clear_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef logic [PtrW-1:0] ptr_t;

    logic [Depth-1:0] mem_q;
    ptr_t             wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ghr_spec.sv
// Global history register: speculative fetch-time history with mispredict repair.
// Define GHR_SPEC_EN for speculative mode; otherwise a committed-only shift register.
module ghr_spec
    import ghr_spec_pkg::*;
#(
    parameter int unsigned HIST_LEN   = HistLenDefault,
    parameter int unsigned CKPT_DEPTH = CkptDepthDefault
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                pred_valid_f_i,
    input  logic                pred_taken_f_i,
    input  logic                stall_ex_i,
    input  logic [1:0]          branch_op_ex_i,
    input  logic                pc_src_res_ex_i,
    input  logic                flush_i,
    output logic [HIST_LEN-1:0] hist_o,
    output logic [HIST_LEN-1:0] hist_commit_o,
    output logic                mispredict_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                err_o
);

    localparam logic [MaxHistLen-1:0] HistRstWide = hist_reset_val();
    localparam logic [HIST_LEN-1:0]   HistRst     = HistRstWide[HIST_LEN-1:0];

    logic                resolve;
    logic [HIST_LEN-1:0] commit_next;
    logic [HIST_LEN-1:0] hist_commit_q;

    assign resolve       = branch_op_ex_i[0] & ~stall_ex_i;
    assign commit_next   = resolve ? {hist_commit_q[HIST_LEN-2:0], pc_src_res_ex_i}
                                   : hist_commit_q;
    assign hist_commit_o = hist_commit_q;

    // Committed history advances even on flush or mispredict.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hist_commit_q <= HistRst;
        end else begin
            hist_commit_q <= commit_next;
        end
    end

`ifdef GHR_SPEC_EN
    logic                fifo_head, fifo_full, fifo_empty;
    logic                repair, pop_ok, push_ok, err_set;
    logic [HIST_LEN-1:0] hist_q, hist_d;
    logic                err_q;
    logic                unused_op_hi;

    assign unused_op_hi = branch_op_ex_i[1];

    assign mispredict_o = resolve & ~fifo_empty & (fifo_head != pc_src_res_ex_i);
    assign repair       = flush_i | mispredict_o;
    assign pop_ok       = resolve & ~fifo_empty & ~repair;
    assign push_ok      = pred_valid_f_i & ~repair & (~fifo_full | pop_ok);
    assign err_set      = (pred_valid_f_i & ~repair & fifo_full & ~pop_ok)
                        | (resolve & fifo_empty);

    ghr_dir_fifo #(
        .Depth (CKPT_DEPTH)
    ) u_dir_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push_ok),
        .din_i     (pred_taken_f_i),
        .pop_i     (pop_ok),
        .clear_i   (repair),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        hist_d = hist_q;
        if (repair) begin
            hist_d = commit_next;
        end else if (push_ok) begin
            hist_d = {hist_q[HIST_LEN-2:0], pred_taken_f_i};
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hist_q <= HistRst;
            err_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            err_q  <= err_q | err_set;
        end
    end

    assign hist_o  = hist_q;
    assign full_o  = fifo_full;
    assign empty_o = fifo_empty;
    assign err_o   = err_q;
`else
    logic unused_spec_in;

    assign unused_spec_in = ^{pred_valid_f_i, pred_taken_f_i, flush_i, branch_op_ex_i[1]};

    assign hist_o       = hist_commit_q;
    assign mispredict_o = 1'b0;
    assign full_o       = 1'b0;
    assign empty_o      = 1'b1;
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_ghr_spec.sv
// Scoreboard bench for ghr_spec; the reference model follows GHR_SPEC_EN as compiled.
module tb_ghr_spec;

    localparam int unsigned HL    = 8;
    localparam int unsigned DEPTH = 4;
`ifdef GHR_SPEC_EN
    localparam bit SpecEn = 1'b1;
`else
    localparam bit SpecEn = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          pred_valid_f_i, pred_taken_f_i, stall_ex_i, pc_src_res_ex_i, flush_i;
    logic [1:0]    branch_op_ex_i;
    logic [HL-1:0] hist_o, hist_commit_o;
    logic          mispredict_o, full_o, empty_o, err_o;

    ghr_spec #(
        .HIST_LEN   (HL),
        .CKPT_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .pred_valid_f_i  (pred_valid_f_i),
        .pred_taken_f_i  (pred_taken_f_i),
        .stall_ex_i      (stall_ex_i),
        .branch_op_ex_i  (branch_op_ex_i),
        .pc_src_res_ex_i (pc_src_res_ex_i),
        .flush_i         (flush_i),
        .hist_o          (hist_o),
        .hist_commit_o   (hist_commit_o),
        .mispredict_o    (mispredict_o),
        .full_o          (full_o),
        .empty_o         (empty_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [HL-1:0] hist;
        logic [HL-1:0] commit;
        bit            full;
        bit            empty;
        bit            err;
        bit            mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: FIFO contents as a plain queue, histories as integers.
    bit            m_fifo[$];
    int unsigned   m_hist, m_commit;
    bit            m_err;
    int unsigned   hist_mask = (1 << HL) - 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_hist   = 1;
        m_commit = 1;
        m_err    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hist"},   64'(hist_o),        64'd1);
        chk({tag, "_commit"}, 64'(hist_commit_o), 64'd1);
        chk({tag, "_empty"},  64'(empty_o),       64'd1);
        chk({tag, "_full"},   64'(full_o),        64'd0);
        chk({tag, "_err"},    64'(err_o),         64'd0);
        chk({tag, "_mis"},    64'(mispredict_o),  64'd0);
    endtask

    // Called at posedge+1: drive one cycle, record expectation, advance model.
    task automatic step(input bit pv, input bit pt, input bit stall, input bit bop,
                        input bit res, input bit fl);
        exp_t        e;
        bit          r, mis;
        int unsigned cn;
        pred_valid_f_i  = pv;
        pred_taken_f_i  = pt;
        stall_ex_i      = stall;
        branch_op_ex_i  = {1'($urandom_range(1)), bop};
        pc_src_res_ex_i = res;
        flush_i         = fl;
        r   = bop && !stall;
        mis = SpecEn && r && m_fifo.size() > 0 && m_fifo[0] != res;
        e.hist   = HL'(m_hist);
        e.commit = HL'(m_commit);
        e.full   = SpecEn && m_fifo.size() == DEPTH;
        e.empty  = !SpecEn || m_fifo.size() == 0;
        e.err    = m_err;
        e.mis    = mis;
        exp_q.push_back(e);
        cn = r ? (((m_commit << 1) | 32'(res)) & hist_mask) : m_commit;
        if (SpecEn) begin
            if (r && m_fifo.size() == 0) m_err = 1'b1;
            if (fl || mis) begin
                m_fifo.delete();
                m_hist = cn;
            end else begin
                if (r && m_fifo.size() > 0) void'(m_fifo.pop_front());
                if (pv) begin
                    if (m_fifo.size() < DEPTH) begin
                        m_fifo.push_back(pt);
                        m_hist = ((m_hist << 1) | 32'(pt)) & hist_mask;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end else begin
            m_hist = cn;
        end
        m_commit = cn;
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid_reset();
        pred_valid_f_i = 1'b0;
        branch_op_ex_i = 2'b00;
        flush_i        = 1'b0;
        reset_n_i      = 1'b0;
        #2;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
    endtask

    // Monitor: every cycle the outputs are presented, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hist",       64'(hist_o),        64'(e.hist));
                chk("commit",     64'(hist_commit_o), 64'(e.commit));
                chk("full",       64'(full_o),        64'(e.full));
                chk("empty",      64'(empty_o),       64'(e.empty));
                chk("err",        64'(err_o),         64'(e.err));
                chk("mispredict", 64'(mispredict_o),  64'(e.mis));
            end
        end
    end

    initial begin
        bit pv, pt, st, bop, res, fl;
        reset_n_i       = 1'b0;
        pred_valid_f_i  = 1'b0;
        pred_taken_f_i  = 1'b0;
        stall_ex_i      = 1'b0;
        branch_op_ex_i  = 2'b00;
        pc_src_res_ex_i = 1'b0;
        flush_i         = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        reset_n_i = 1'b1;

        // Three resolutions T, T, N from reset.
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("commit_ttn", 64'(hist_commit_o), 64'h0E);
        step(0, 0, 1, 1, 1, 0);  // stalled EX must not commit
        chk("stall_hold", 64'(hist_commit_o), 64'h0E);
        mid_reset();

        // Correctly predicted pair.
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);

        // Mispredict with a simultaneous push.
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Fill, overflow, then push with a correct resolve while full.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        mid_reset();

        // Resolve while empty.
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        mid_reset();

        // Flush with two in flight.
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        mid_reset();

        // Randomised traffic, mostly well-predicted.
        for (int i = 0; i < 3000; i++) begin
            pv  = $urandom_range(99) < 55;
            pt  = $urandom_range(1);
            st  = $urandom_range(99) < 15;
            bop = $urandom_range(99) < 50;
            fl  = $urandom_range(99) < 3;
            if (m_fifo.size() > 0 && $urandom_range(9) < 8) res = m_fifo[0];
            else res = 1'($urandom_range(1));
            step(pv, pt, st, bop, res, fl);
            if ($urandom_range(999) < 4) mid_reset();
        end

        @(negedge clk_i);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
